// File: rtl/dmem_wait_unit_pkg.sv
// Shared definitions for the wait-state data memory: RV32I load/store funct3 codes,
// the access FSM state type and the misalignment predicate.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Halves must be 2-byte aligned, words 4-byte aligned; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_wait_unit_if.sv
// Core-to-data-memory bus. The core raises req and holds we/funct3/addr/wdata stable until
// the one-cycle done pulse; rdata and fault are meaningful only while done is high.
interface dmem_wait_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              stall;
  logic              fault;

  modport master (
    output req, we, funct3, addr, wdata,
    input  rdata, done, stall, fault
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output rdata, done, stall, fault
  );
endinterface

// File: rtl/dmem_wait_unit_load_align.sv
// Combinational load formatter: picks the byte/half lane of a RAM word and applies
// RV32I sign or zero extension. Unsupported funct3 codes yield zero.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[8*off +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_wait_unit.sv
// Data memory with WAIT_CYCLES wait states and a req/done handshake (IDLE->BUSY->DONE).
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module dmem_wait_unit
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic   clk,
  input  logic   reset,
  dmem_wait_unit_if.slave bus,
  output state_t state
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               fault_q;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [IDX_W-1:0]   idx;
  logic [1:0]         off;
  logic               access;
  logic               trap;
  logic [3:0]         be;
  logic [31:0]        lane_data;
  logic [31:0]        mem_word;
  logic [31:0]        load_res;
  logic               unused_addr;

  // Address bits above the RAM index wrap modulo the depth.
  assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W+2];

  assign idx    = addr_q[IDX_W+1:2];
  assign off    = addr_q[1:0];
  assign access = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(f3_q, off);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.req) begin
        state_d = BUSY;
        cnt_d   = WAIT_INIT;
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req) begin
        we_q    <= bus.we;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr[IDX_W+1:0];
        wdata_q <= bus.wdata;
      end
      if (access) begin
        rdata_q <= (we_q || trap) ? 32'h0 : load_res;
        fault_q <= trap;
      end
    end
  end

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    be        = 4'b0000;
    lane_data = wdata_q;
    case (f3_q)
      F3_B: begin
        be        = 4'b0001 << off;
        lane_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!we_q || trap) be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (access) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  assign mem_word = mem[idx];

  load_align u_load_align (
    .word   (mem_word),
    .funct3 (f3_q),
    .off    (off),
    .result (load_res)
  );

  assign bus.done  = (state_q == DONE);
  assign bus.stall = bus.req & ~bus.done;
  assign bus.rdata = rdata_q;
  assign bus.fault = fault_q & bus.done;
  assign state     = state_q;

endmodule

// File: tb/tb_dmem_wait_unit.sv
// Directed bench for dmem_wait_unit: three instances (1, 0 and 3 wait states) sharing
// operand lines, with req steered to one instance at a time and a queue of expected results.
module tb_dmem_wait_unit;
  import rv_mem_pkg::*;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  int          sel = 0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  state_t st_m, st_z, st_t;

  dmem_wait_unit_if #(.ADDR_W(32)) if_m ();
  dmem_wait_unit_if #(.ADDR_W(32)) if_z ();
  dmem_wait_unit_if #(.ADDR_W(32)) if_t ();

  assign if_m.req = req && (sel == 0);
  assign if_z.req = req && (sel == 1);
  assign if_t.req = req && (sel == 2);
  assign if_m.we = we;  assign if_m.funct3 = funct3;  assign if_m.addr = addr;  assign if_m.wdata = wdata;
  assign if_z.we = we;  assign if_z.funct3 = funct3;  assign if_z.addr = addr;  assign if_z.wdata = wdata;
  assign if_t.we = we;  assign if_t.funct3 = funct3;  assign if_t.addr = addr;  assign if_t.wdata = wdata;

  dmem_wait_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .ADDR_W(32)) u_m (
    .clk(clk), .reset(reset), .bus(if_m), .state(st_m));
  dmem_wait_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_W(32)) u_z (
    .clk(clk), .reset(reset), .bus(if_z), .state(st_z));
  dmem_wait_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .ADDR_W(32)) u_t (
    .clk(clk), .reset(reset), .bus(if_t), .state(st_t));

  always #5 clk = ~clk;

  logic        done_s, stall_s, fault_s;
  logic [31:0] rdata_s;
  always_comb begin
    done_s  = if_m.done;  stall_s = if_m.stall;  fault_s = if_m.fault;  rdata_s = if_m.rdata;
    if (sel == 1) begin
      done_s = if_z.done;  stall_s = if_z.stall;  fault_s = if_z.fault;  rdata_s = if_z.rdata;
    end else if (sel == 2) begin
      done_s = if_t.done;  stall_s = if_t.stall;  fault_s = if_t.fault;  rdata_s = if_t.rdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int wait_of(input int s);
    case (s)
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // One access on instance s; checks latency, stall length, rdata, fault and done width.
  task automatic access(input int s, input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input bit chk_rd,
                        input bit exp_fault, input string tag);
    int lat, cyc, stalls;
    bit seen;
    logic [31:0] e;
    lat = wait_of(s) + 2;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    sel = s; we = w; funct3 = f3; addr = a; wdata = d; req = 1'b1;
    #1;
    cyc = 0; stalls = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done_s) seen = 1'b1;
      else begin
        if (stall_s) stalls++;
        @(negedge clk);
        cyc++;
      end
    end
    e = exp_q.pop_front();
    chk({tag, " done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      chk({tag, " latency"}, cyc, lat);
      chk({tag, " stall_cycles"}, stalls, lat);
      if (chk_rd) chk({tag, " rdata"}, rdata_s, e);
      chk({tag, " fault"}, {31'b0, fault_s}, {31'b0, exp_fault});
    end
    req = 1'b0;
    @(negedge clk);
    chk({tag, " done_width"}, {31'b0, done_s}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst state", 32'(st_m), 32'(IDLE));
    chk("rst rdata", if_m.rdata, 32'h0);
    chk("rst done", {31'b0, if_m.done}, 32'd0);
    chk("rst fault", {31'b0, if_m.fault}, 32'd0);
    chk("rst stall_lo", {31'b0, if_m.stall}, 32'd0);
    req = 1'b1; #1;
    chk("rst stall_hi", {31'b0, if_m.stall}, 32'd1);
    req = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // Word store/load and sub-word loads (1 wait state)
    access(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1'b0, "sw10");
    access(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1, 1'b0, "lw10");
    access(0, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1, 1'b0, "lb13");
    access(0, 0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1, 1'b0, "lbu13");
    access(0, 0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1, 1'b0, "lh12");
    access(0, 0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 1, 1'b0, "lhu10");
    access(0, 0, F3_B,  32'h11, 32'h0,        32'hFFFFFFBE, 1, 1'b0, "lb11");

    // Byte-enable stores preserve neighbouring bytes
    access(0, 1, F3_B,  32'h11, 32'h11223344, 32'h0,        0, 1'b0, "sb11");
    access(0, 0, F3_W,  32'h10, 32'h0,        32'hDEAD44EF, 1, 1'b0, "lw_sb");
    access(0, 1, F3_H,  32'h12, 32'hAAAA5555, 32'h0,        0, 1'b0, "sh12");
    access(0, 0, F3_W,  32'h10, 32'h0,        32'h555544EF, 1, 1'b0, "lw_sh");
    access(0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0,       0, 1'b0, "s011");
    access(0, 0, F3_W,  32'h10, 32'h0,        32'h555544EF, 1, 1'b0, "lw_s011");
    access(0, 0, 3'b110, 32'h10, 32'h0,       32'h0,        1, 1'b0, "l110");

    // Zero and three wait states
    access(1, 1, F3_W,  32'h8,  32'h600DCAFE, 32'h0,        0, 1'b0, "z_sw");
    access(1, 0, F3_HU, 32'hA,  32'h0,        32'h0000600D, 1, 1'b0, "z_lhu");
    access(2, 1, F3_W,  32'h4,  32'h0000A5A5, 32'h0,        0, 1'b0, "t_sw");
    access(2, 0, F3_H,  32'h4,  32'h0,        32'hFFFFA5A5, 1, 1'b0, "t_lh");

    // req held high: done every WAIT_CYCLES+3 cycles
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd17);
    @(negedge clk);
    sel = 2; we = 1'b0; funct3 = F3_W; addr = 32'h4; req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done_s) begin
        if (exp_q.size() > 0) chk("hold done_cycle", c, exp_q.pop_front());
        else chk("hold extra_done", c, 32'hFFFFFFFF);
        chk("hold rdata", rdata_s, 32'h0000A5A5);
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("hold pending", exp_q.size(), 32'd0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (8) @(negedge clk);

    // Reset during BUSY drops the store
    access(0, 1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 0, 1'b0, "sw20_old");
    @(negedge clk);
    sel = 0; we = 1'b1; funct3 = F3_W; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(negedge clk);
    chk("mid state_busy", 32'(st_m), 32'(BUSY));
    reset = 1'b0; #1;
    chk("mid state_idle", 32'(st_m), 32'(IDLE));
    chk("mid stall_eq_req", {31'b0, if_m.stall}, 32'd1);
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid no_done", {31'b0, if_m.done}, 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    access(0, 0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1, 1'b0, "lw20_kept");

    // Address wrap modulo depth
    access(0, 1, F3_W, 32'h0,   32'h0BADF00D, 32'h0,        0, 1'b0, "sw0");
    access(0, 0, F3_W, 32'h100, 32'h0,        32'h0BADF00D, 1, 1'b0, "lw100");

    // Misaligned accesses
    if (TRAP) begin
      access(0, 1, F3_W, 32'h22, 32'h99999999, 32'h0,        1, 1'b1, "sw22_trap");
      access(0, 0, F3_W, 32'h20, 32'h0,        32'hCAFEF00D, 1, 1'b0, "lw20_unch");
      access(0, 0, F3_H, 32'h21, 32'h0,        32'h0,        1, 1'b1, "lh21_trap");
    end else begin
      access(0, 0, F3_W, 32'h22, 32'h0,        32'hCAFEF00D, 1, 1'b0, "lw22");
      access(0, 0, F3_H, 32'h21, 32'h0,        32'hFFFFF00D, 1, 1'b0, "lh21");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
